// File: rtl/ps2_mouse_cursor.sv
// Receive-only PS/2 mouse front end: synchronises the PS/2 lines, deserialises
// device frames, assembles 3-byte stream packets and tracks a clamped cursor.
module ps2_mouse_cursor #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [9:0] cursor_x,
  output logic [9:0] cursor_y,
  output logic       btn_left,
  output logic       btn_right,
  output logic       btn_middle,
  output logic       packet_valid,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - 1);
  localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} rx_state_t;

  // frame layout after shifting: [7:0] data, [8] odd parity, [9] stop
  function automatic logic frame_ok(input logic [9:0] f);
    return (^f[8:0]) & f[9];
  endfunction

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev;
  logic                   clk_s, dat_s, fall;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  assign fall  = clk_prev & ~clk_s;

  // synchroniser chains reset to the idle-high bus level
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_s;
    end
  end

  rx_state_t     state;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [TW-1:0] tcount;
  logic          byte_valid;
  logic [7:0]    rx_byte;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      shreg       <= 10'd0;
      tcount      <= '0;
      byte_valid  <= 1'b0;
      rx_byte     <= 8'd0;
      frame_error <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          tcount <= '0;
          if (fall && !dat_s) begin
            state   <= SHIFT;
            bit_cnt <= 4'd1;
          end
        end
        SHIFT: begin
          // a falling edge takes priority over an expiring timeout
          if (fall) begin
            shreg   <= {dat_s, shreg[9:1]};
            tcount  <= '0;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd10) state <= CHECK;
          end else if (tcount == TW'(TIMEOUT_CYCLES)) begin
            state       <= IDLE;
            tcount      <= '0;
            frame_error <= 1'b1;
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
        CHECK: begin
          state   <= IDLE;
          rx_byte <= shreg[7:0];
          if (frame_ok(shreg)) byte_valid  <= 1'b1;
          else                 frame_error <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [1:0]         byte_idx;
  logic [7:0]         hdr, dx_byte;
  logic signed [11:0] dx, dy, nx, ny;
  logic [9:0]         nx_c, ny_c;

  // movement deltas are 9-bit two's complement, forced to zero on overflow
  always_comb begin
    dx = hdr[6] ? 12'sd0 : {{4{hdr[4]}}, dx_byte};
    dy = hdr[7] ? 12'sd0 : {{4{hdr[5]}}, rx_byte};
    nx = $signed({2'b00, cursor_x}) + dx;
    ny = $signed({2'b00, cursor_y}) - dy;
    if (nx[11])          nx_c = 10'd0;
    else if (nx > X_MAX) nx_c = X_MAX[9:0];
    else                 nx_c = nx[9:0];
    if (ny[11])          ny_c = 10'd0;
    else if (ny > Y_MAX) ny_c = Y_MAX[9:0];
    else                 ny_c = ny[9:0];
  end

  // packet assembly; the third byte is applied directly from rx_byte
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_idx     <= 2'd0;
      hdr          <= 8'd0;
      dx_byte      <= 8'd0;
      cursor_x     <= 10'(SCREEN_W / 2);
      cursor_y     <= 10'(SCREEN_H / 2);
      btn_left     <= 1'b0;
      btn_right    <= 1'b0;
      btn_middle   <= 1'b0;
      packet_valid <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      if (frame_error) begin
        byte_idx <= 2'd0;
      end else if (byte_valid) begin
        case (byte_idx)
          2'd0: begin
            if (rx_byte[3]) begin
              hdr      <= rx_byte;
              byte_idx <= 2'd1;
            end else begin
              byte_idx <= 2'd0;
            end
          end
          2'd1: begin
            dx_byte  <= rx_byte;
            byte_idx <= 2'd2;
          end
          2'd2: begin
            cursor_x     <= nx_c;
            cursor_y     <= ny_c;
            btn_left     <= hdr[0];
            btn_right    <= hdr[1];
            btn_middle   <= hdr[2];
            packet_valid <= 1'b1;
            byte_idx     <= 2'd0;
          end
          default: byte_idx <= 2'd0;
        endcase
      end else begin
        byte_idx <= byte_idx;
      end
    end
  end

endmodule

// File: doc/ps2_mouse_cursor.md
Name: ps2_mouse_cursor

Overview:
- Receive-only PS/2 mouse front end for the paint datapath; sits upstream of the processor, which reads the cursor position and buttons to decide which pixel index to write into VGA memory.
- Synchronises the raw PS/2 lines into the VGA_CTRL_CLK domain and deserialises 11-bit device frames.
- Assembles standard 3-byte stream-mode packets and maintains a clamped on-screen cursor position.
- Stream-mode enable (host command 0xF4) is issued by a separate block; this block never drives the bus.

Parameters:
- SCREEN_W, 640, horizontal pixel count; cursor_x range 0..SCREEN_W-1.
- SCREEN_H, 480, vertical pixel count; cursor_y range 0..SCREEN_H-1.
- SYNC_STAGES, 2, flip-flop stages on each PS/2 input.
- TIMEOUT_CYCLES, 25000, clock cycles (1 ms at 25 MHz) without a PS/2 falling edge before an in-progress frame is abandoned.

Ports:
- clock  in  1  system clock (VGA_CTRL_CLK).
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock line, asynchronous.
- ps2_dat  in  1  raw PS/2 data line, asynchronous.
- cursor_x  out  10  cursor column.
- cursor_y  out  10  cursor row, 0 = top.
- btn_left  out  1  left button state from the last packet.
- btn_right  out  1  right button state from the last packet.
- btn_middle  out  1  middle button state from the last packet.
- packet_valid  out  1  one-cycle pulse when a packet is applied.
- frame_error  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

Behaviour:
- Interface: one clock, named clock; reset is synchronous and active-high, named reset. All state is updated only on the rising edge of clock.
- Reset values: cursor_x = SCREEN_W/2 (320), cursor_y = SCREEN_H/2 (240), all buttons 0, packet_valid 0, frame_error 0, receiver IDLE, byte index 0, timeout counter 0.
- A reset asserted mid-frame or mid-packet discards all partial data.
- Input synchronisation: ps2_clk and ps2_dat each pass through SYNC_STAGES flip-flops.
- Falling-edge detect: fall = previous synced clk 1 AND current synced clk 0. Data is sampled in the same cycle fall is seen.
- Receiver FSM, IDLE:
  - fall with dat=0 (start bit): go to SHIFT, bit count = 1.
  - fall with dat=1: ignored.
- Receiver FSM, SHIFT:
  - Each fall shifts in one bit: 8 data bits LSB first, then odd parity, then stop.
  - On the fall that captures bit 10 (stop), go to CHECK.
  - The timeout counter clears on every fall and increments otherwise.
  - When the counter reaches TIMEOUT_CYCLES: go to IDLE, pulse frame_error, reset byte index to 0.
  - If fall and timeout coincide, the fall wins.
- Receiver FSM, CHECK (exactly one cycle):
  - Good frame: XOR of the 8 data bits and the parity bit = 1, and stop = 1. Produce an internal byte_valid pulse.
  - Bad frame: pulse frame_error, reset byte index to 0.
  - Always return to IDLE.
- Packet assembly, on byte_valid:
  - Index 0: accept only if bit3 = 1, else drop silently and stay at index 0 (resync). Latch L=b0, R=b1, M=b2, Xsign=b4, Ysign=b5, Xovf=b6, Yovf=b7.
  - Index 1: latch dx byte.
  - Index 2: latch dy byte, raise apply for one cycle, index returns to 0.
- Delta arithmetic:
  - dx = {Xsign, byte1} as 9-bit two's complement (-256..255); dy likewise.
  - If the axis overflow bit is set, that axis delta = 0.
  - Compute in 12-bit signed: nx = x + dx, ny = y - dy (PS/2 +dy means up; screen y grows down).
  - Clamp nx to 0..SCREEN_W-1 and ny to 0..SCREEN_H-1.
- Latency: the byte 2 stop-bit fall is detected at cycle N. CHECK is cycle N+1. Cursor, buttons and packet_valid update together on the edge ending cycle N+2 and are held until the next packet.
- frame_error and packet_valid are never high in the same cycle.

Test Plan:
- Reset asserted 3 cycles then released -> cursor_x=320, cursor_y=240, buttons 0, no pulses for 1000 idle cycles.
- From reset, frames 0x09, 0x0A, 0x05 at 12.5 kHz PS/2 clock -> exactly one packet_valid; btn_left=1, cursor_x=330, cursor_y=235.
- Clamping:
  - From x=5, send 0x18, 0xF6, 0x00 (dx=-10) -> cursor_x=0.
  - From x=635, send 0x08, 0x14, 0x00 (dx=+20) -> cursor_x=639.
  - From y=2, send 0x28, 0x00, 0xF0 (dy=-16) -> cursor_y=18.
- Error and resync:
  - Byte 1 sent with wrong parity -> one frame_error pulse, no packet_valid.
  - Next clean 0x08, 0x01, 0x01 -> x+1, y-1.
  - A leading byte 0x00 (bit3=0) is dropped without error; the following packet is still applied.
- Timeout: send start plus 4 bits, hold ps2_clk high for TIMEOUT_CYCLES -> one frame_error. A following full packet is applied correctly.
- Overflow: packet 0x48, 0xFF, 0x03 -> cursor_x unchanged, cursor_y decremented by 3, packet_valid pulses.
